// File: rtl/pipeline_perf_pkg.sv
// Shared definitions for the pipeline performance counter bank:
// event slot numbering, default bank size and the increment helper.
package pipeline_perf_pkg;

  localparam int NUM_EVENTS_DEFAULT = 4;

  localparam int EV_STALL      = 0;
  localparam int EV_MISPREDICT = 1;
  localparam int EV_FLUSH      = 2;
  localparam int EV_LOADUSE    = 3;

  // Widest counter the helper supports; narrower counters zero-extend into it.
  localparam int SAT_W = 64;

  // Returns {overflow, next}. Overflow flags an increment attempted at the
  // all-ones value; next either sticks at all-ones or wraps to zero.
  function automatic logic [SAT_W:0] sat_inc(input logic [SAT_W-1:0] value,
                                            input int unsigned      width,
                                            input logic             saturate);
    logic [SAT_W-1:0] max_val;
    logic [SAT_W:0]   result;
    if (width >= SAT_W) max_val = '1;
    else                max_val = (64'd1 << width) - 64'd1;
    result = '0;
    if (value >= max_val) begin
      result[SAT_W]     = 1'b1;
      result[SAT_W-1:0] = saturate ? max_val : '0;
    end else begin
      result[SAT_W-1:0] = value + 64'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// One CNT_W-bit performance counter with hold, clear, wrap/saturate
// arithmetic and a sticky overflow flag. capture_val is the value the
// counter takes after this cycle's increment, ignoring clear, so that a
// snapshot taken in a clear cycle still sees this cycle's event.
module perf_counter_cell
  import pipeline_perf_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             hold,
  input  logic             inc,
  output logic [CNT_W-1:0] capture_val,
  output logic             ovf
);

  logic [CNT_W-1:0] count;
  logic [SAT_W:0]   inc_res;
  logic [CNT_W-1:0] inc_val;
  logic             step_ovf;
  logic             step_en;

  assign inc_res     = sat_inc(SAT_W'(count), CNT_W, SATURATE);
  assign inc_val     = inc_res[CNT_W-1:0];
  assign step_ovf    = inc_res[SAT_W];
  assign step_en     = inc & ~hold;
  assign capture_val = step_en ? inc_val : count;

  if (CNT_W < SAT_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = |inc_res[SAT_W-1:CNT_W];
  end

  // Counter and sticky overflow update; clear wins over counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clear) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (step_en) begin
      count <= inc_val;
      if (step_ovf) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_perf_counter_bank.sv
// Bank of one cycle counter plus NUM_EVENTS event counters with a window
// timer for periodic snapshots, on-demand snapshots and a registered
// indexed read port over the snapshot registers.
module pipeline_perf_counter_bank
  import pipeline_perf_pkg::*;
#(
  parameter int NUM_EVENTS = NUM_EVENTS_DEFAULT,
  parameter int CNT_W      = 32,
  parameter bit SATURATE   = 1'b1,
  parameter int WINDOW_W   = 16,
  localparam int IDX_W     = $clog2(NUM_EVENTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  freeze,
  input  logic                  clear,
  input  logic [NUM_EVENTS-1:0] events,
  input  logic [WINDOW_W-1:0]   window_len,
  input  logic                  snap_req,
  input  logic                  rd_req,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_valid,
  output logic [CNT_W-1:0]      rd_data,
  output logic [NUM_EVENTS:0]   ovf,
  output logic                  snap_pulse,
  output logic [15:0]           snap_count
);

  localparam int NUM_CNT = NUM_EVENTS + 1;

  logic                count_mode;
  logic                auto_snap;
  logic                snap_take;
  logic [NUM_CNT-1:0]  cnt_inc;
  logic [CNT_W-1:0]    live_next [NUM_CNT];
  logic [CNT_W-1:0]    snap_bank [NUM_CNT];
  logic [WINDOW_W-1:0] win_timer;
  logic [CNT_W-1:0]    rd_mux;

  assign count_mode = enable & ~freeze;
  assign cnt_inc    = {events, 1'b1};

  // A timer already past a shortened window fires on the next counted cycle.
  assign auto_snap = count_mode && (window_len != '0) &&
                     (win_timer >= (window_len - WINDOW_W'(1)));
  assign snap_take = snap_req | auto_snap;

  // Slot 0 is the free-running cycle counter, slot i+1 counts events[i].
  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    perf_counter_cell #(
      .CNT_W   (CNT_W),
      .SATURATE(SATURATE)
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .hold       (~count_mode),
      .inc        (cnt_inc[i]),
      .capture_val(live_next[i]),
      .ovf        (ovf[i])
    );
  end

  // Window timer advances only on counted cycles and reloads when it fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_timer <= '0;
    end else if (clear) begin
      win_timer <= '0;
    end else if (count_mode && (window_len != '0)) begin
      win_timer <= auto_snap ? '0 : win_timer + WINDOW_W'(1);
    end
  end

  // Snapshot bank captures post-update live values, one snapshot per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CNT; i++) snap_bank[i] <= '0;
      snap_pulse <= 1'b0;
      snap_count <= '0;
    end else begin
      snap_pulse <= snap_take;
      if (snap_take) begin
        for (int i = 0; i < NUM_CNT; i++) snap_bank[i] <= live_next[i];
        snap_count <= snap_count + 16'd1;
      end
    end
  end

  // Read mux returns zero for indices beyond the last event counter.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_idx == IDX_W'(i)) rd_mux = snap_bank[i];
    end
  end

  // Registered read port: data and valid appear the cycle after the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= rd_mux;
    end
  end

endmodule

// File: doc/pipeline_perf_counter_bank.md
Name: pipeline_perf_counter_bank

Overview:
Parametrised successor to the pipeline performance monitor. It holds one free-running cycle counter plus NUM_EVENTS event counters, for example stall, branch mispredict, flush and load-use hazard. It adds:
- selectable wrap or saturate arithmetic
- sticky overflow flags
- global enable and freeze
- periodic or on-demand snapshots
- an indexed, registered read port for the debug/CSR side

It sits beside the pipeline control unit and samples single-cycle event strobes.

Parameters:
NUM_EVENTS, 4, number of event counters (1..16)
CNT_W, 32, width of every counter and snapshot register (8..64)
SATURATE, 1, 1 = counters stop at all-ones; 0 = counters wrap to 0
WINDOW_W, 16, width of the sampling-window length input; 0-length window disables auto-snapshot

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
enable  in  1  counting enabled when high
freeze  in  1  hold all counters; takes priority over enable
clear  in  1  synchronous zero of live counters and overflow flags
events  in  NUM_EVENTS  per-cycle event strobes, bit i increments counter i
window_len  in  WINDOW_W  auto-snapshot period in counted cycles; 0 = off
snap_req  in  1  request an immediate snapshot
rd_req  in  1  read request
rd_idx  in  $clog2(NUM_EVENTS+1)  0 = cycle counter, i = event counter i-1
rd_valid  out  1  read data valid, one cycle after rd_req
rd_data  out  CNT_W  snapshot value of the selected counter
ovf  out  NUM_EVENTS+1  sticky overflow flags, bit 0 = cycle counter
snap_pulse  out  1  one-cycle pulse when a snapshot is taken
snap_count  out  16  number of snapshots taken; wraps

Behaviour:
- Reset (rst=1 at posedge): all live counters, snapshots, ovf, rd_data, rd_valid, snap_pulse, snap_count and the window timer go to 0. Reset mid-read drops the pending rd_valid.
- Mode per cycle:
  - COUNT when enable=1 and freeze=0.
  - HOLD otherwise. In HOLD all counters and the window timer hold.
  - There is no explicit FSM register beyond this decode plus the window timer.
- In COUNT:
  - The cycle counter increments every cycle.
  - Event counter i increments when events[i]=1.
  - Increments take effect at the posedge where the strobe is sampled; read back through a snapshot, the latency is 1 cycle.
- Width and overflow rules:
  - SATURATE=1: a counter at 2^CNT_W-1 stays there, and its ovf bit sets on the attempted increment.
  - SATURATE=0: the counter wraps to 0, and its ovf bit sets on the wrap.
  - ovf bits stay set until clear or rst.
- Window timer:
  - Counts COUNT cycles when window_len != 0.
  - When the timer reaches window_len-1, it reloads to 0 and fires an auto-snapshot the same cycle.
  - Changing window_len mid-window takes effect immediately. If the timer is already >= the new window_len-1, the snapshot fires on the next COUNT cycle.
- Snapshot (auto or snap_req, including in HOLD):
  - All snapshot registers capture the live values as they will be after this cycle's update, i.e. including this cycle's events.
  - snap_pulse=1 for the following cycle and snap_count increments.
  - Both sources in the same cycle produce one snapshot.
- clear:
  - Live counters, ovf and the window timer become 0.
  - Events in the clear cycle are discarded.
  - Snapshot registers are not cleared.
  - A snapshot in the same cycle as clear captures the pre-clear values plus this cycle's events, then the live counters clear.
- Read port:
  - rd_req sampled at a posedge produces rd_valid=1 and rd_data=snapshot[rd_idx] on the next cycle.
  - Back-to-back reads are allowed, one per cycle.
  - rd_idx > NUM_EVENTS returns 0 with rd_valid=1.
  - A snapshot and a read in the same cycle return the old snapshot value.
- Precedence: rst > clear > freeze > enable.

Decomposition:
- Package pipeline_perf_pkg holds:
  - the event index constants (EV_STALL=0, EV_MISPREDICT=1, EV_FLUSH=2, EV_LOADUSE=3)
  - the NUM_EVENTS default
  - a function sat_inc(value, saturate) returning {overflow, next}
- One sub-module, perf_counter_cell: a single CNT_W counter with inc, clear, hold, SATURATE and a sticky ovf. It is instantiated NUM_EVENTS+1 times by generate.
- The window timer, snapshot bank and read mux live in the top module.

Test Plan:
1. Reset, then enable=1 for 5 cycles, events=0, then snap_req, then read idx 0..4 → cycle=5 (the snapshot cycle's own increment is included, so 6 if that cycle counted), events all 0, ovf=0.
2. events[0]=1 for 3 cycles, events[1] pulsed twice in 3 cycles, then snap and read → idx1=3, idx2=2; rd_valid asserts exactly 1 cycle after each rd_req.
3. CNT_W=8, SATURATE=1, events[0] held high for 300 cycles, then snap → idx1=255, ovf[1]=1. With SATURATE=0 the same stimulus gives idx1=44 (300 mod 256) and ovf[1]=1.
4. window_len=10, enable=1 for 35 cycles → snap_pulse at cycles 10, 20 and 30 of counting, snap_count=3. With freeze=1 for 5 cycles in the middle, the pulses shift by 5.
5. clear and snap_req in the same cycle with events[2]=1 and counter2=7 → snapshot idx3=8, live counter2=0, ovf=0; a following snap gives idx3=0.
6. rst asserted mid-run with rd_req pending → next cycle rd_valid=0, all reads return 0, snap_count=0.
